// File: rtl/ntt_delay_commutator.sv
// Delay-commutator (SDF reorder) ahead of an NTT butterfly: re-pairs the a/b
// streams so that samples DELAY apart leave together on x_out/y_out.
module ntt_delay_commutator #(
    parameter int WIDTH     = 28,
    parameter int DELAY     = 16,
    parameter int LOG_DELAY = $clog2(DELAY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic             sop_out
);

    localparam int AW = (LOG_DELAY > 0) ? LOG_DELAY : 1;
    localparam int KW = LOG_DELAY + 1;

    logic [KW-1:0]    k_q, k_d;
    logic             primed_q, primed_d;
    logic             valid_q, valid_d;
    logic             sop_q, sop_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;

    logic             h;
    logic [AW-1:0]    j;
    logic             p_we, q_we;
    logic [WIDTH-1:0] q_wdata;
    logic [WIDTH-1:0] p_rd, q_rd;

    // p_mem keeps the first-half b samples for a full 2D period; q_mem holds
    // first-half a samples, then is reused for second-half b samples.
    logic [WIDTH-1:0] p_mem [DELAY];
    logic [WIDTH-1:0] q_mem [DELAY];

    assign h = k_q[LOG_DELAY];

    generate
        if (LOG_DELAY > 0) begin : g_idx
            assign j = k_q[AW-1:0];
        end else begin : g_idx_single
            assign j = '0;
        end
    endgenerate

    assign p_rd = p_mem[j];
    assign q_rd = q_mem[j];

    always_comb begin
        k_d      = k_q;
        primed_d = primed_q;
        valid_d  = 1'b0;
        sop_d    = 1'b0;
        x_d      = x_q;
        y_d      = y_q;
        p_we     = 1'b0;
        q_we     = 1'b0;
        q_wdata  = a_in;
        if (valid_in) begin
            k_d     = k_q + KW'(1);
            valid_d = primed_q;
            if (h) begin
                // Second half: pair the stored a with the live a, then park b.
                x_d     = q_rd;
                y_d     = a_in;
                q_we    = 1'b1;
                q_wdata = b_in;
                sop_d   = (j == '0);
            end else begin
                if (primed_q) begin
                    x_d = p_rd;
                    y_d = q_rd;
                end
                p_we = 1'b1;
                q_we = 1'b1;
                if (j == AW'(DELAY - 1)) begin
                    primed_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q      <= '0;
            primed_q <= 1'b0;
            valid_q  <= 1'b0;
            sop_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            k_q      <= k_d;
            primed_q <= primed_d;
            valid_q  <= valid_d;
            sop_q    <= sop_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    always_ff @(posedge clk) begin
        if (p_we) begin
            p_mem[j] <= b_in;
        end
        if (q_we) begin
            q_mem[j] <= q_wdata;
        end
    end

    assign valid_out = valid_q;
    assign sop_out   = sop_q;
    assign x_out     = x_q;
    assign y_out     = y_q;

endmodule

// File: tb/tb_ntt_delay_commutator.sv
// Bench for ntt_delay_commutator: three instances (D=4, D=1, D=16) against a
// history-based reference of the re-pairing, through an expected-output queue.
module tb_ntt_delay_commutator;

    typedef struct packed {
        logic [27:0] x;
        logic [27:0] y;
        logic        sop;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        vin [3];
    logic [27:0] ain [3];
    logic [27:0] bin [3];
    logic        vo  [3];
    logic [27:0] xo  [3];
    logic [27:0] yo  [3];
    logic        so  [3];

    int total = 0;
    int bad   = 0;

    exp_t        sb [$];
    logic [27:0] ah [$];
    logic [27:0] bh [$];
    int          kk;
    int          dcur;
    logic [27:0] hold_x, hold_y;
    int          n_out, n_sop;

    ntt_delay_commutator #(.WIDTH(28), .DELAY(4)) u_d4 (
        .clk(clk), .rst(rst), .valid_in(vin[0]), .a_in(ain[0]), .b_in(bin[0]),
        .valid_out(vo[0]), .x_out(xo[0]), .y_out(yo[0]), .sop_out(so[0]));

    ntt_delay_commutator #(.WIDTH(28), .DELAY(1)) u_d1 (
        .clk(clk), .rst(rst), .valid_in(vin[1]), .a_in(ain[1]), .b_in(bin[1]),
        .valid_out(vo[1]), .x_out(xo[1]), .y_out(yo[1]), .sop_out(so[1]));

    ntt_delay_commutator #(.WIDTH(28), .DELAY(16)) u_d16 (
        .clk(clk), .rst(rst), .valid_in(vin[2]), .a_in(ain[2]), .b_in(bin[2]),
        .valid_out(vo[2]), .x_out(xo[2]), .y_out(yo[2]), .sop_out(so[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input int d);
        sb.delete();
        ah.delete();
        bh.delete();
        kk     = 0;
        dcur   = d;
        hold_x = '0;
        hold_y = '0;
        n_out  = 0;
        n_sop  = 0;
    endtask

    // Called from posedge+1: reset lands mid-cycle, outputs checked before the next edge.
    task automatic do_reset(input int sel, input int d);
        #3;
        rst = 1'b0;
        #1;
        chk("rst_valid", 64'(vo[sel]), 64'd0);
        chk("rst_sop",   64'(so[sel]), 64'd0);
        chk("rst_x",     64'(xo[sel]), 64'd0);
        chk("rst_y",     64'(yo[sel]), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear(d);
    endtask

    task automatic step(input int sel, input logic v, input logic [27:0] a, input logic [27:0] b);
        exp_t e;
        logic exp_v;
        vin[sel] = v;
        ain[sel] = a;
        bin[sel] = b;
        exp_v    = v && (kk >= dcur);
        @(posedge clk);
        if (v) begin
            ah.push_back(a);
            bh.push_back(b);
            if (kk >= dcur) begin
                if (((kk / dcur) % 2) == 1) begin
                    e.x = ah[kk - dcur];
                    e.y = ah[kk];
                end else begin
                    e.x = bh[kk - 2 * dcur];
                    e.y = bh[kk - dcur];
                end
                e.sop = ((kk % (2 * dcur)) == dcur);
                sb.push_back(e);
            end
            kk++;
        end
        #1;
        vin[sel] = 1'b0;
        chk("valid_out", 64'(vo[sel]), 64'(exp_v));
        if (vo[sel] === 1'b1) begin
            chk("sb_avail", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("x_out",   64'(xo[sel]), 64'(e.x));
                chk("y_out",   64'(yo[sel]), 64'(e.y));
                chk("sop_out", 64'(so[sel]), 64'(e.sop));
                hold_x = e.x;
                hold_y = e.y;
                n_out++;
                if (so[sel] === 1'b1) n_sop++;
            end
        end else begin
            chk("sop_idle", 64'(so[sel]), 64'd0);
            chk("x_hold",   64'(xo[sel]), 64'(hold_x));
            chk("y_hold",   64'(yo[sel]), 64'(hold_y));
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vin[i] = 1'b0;
            ain[i] = '0;
            bin[i] = '0;
        end
        model_clear(4);
        @(posedge clk);
        #1;

        // Test 1: D=4 continuous stream.
        do_reset(0, 4);
        for (int k = 0; k < 16; k++) step(0, 1'b1, 28'(k), 28'(100 + k));
        step(0, 1'b0, '0, '0);
        chk("t1_outputs", 64'(n_out), 64'd12);
        chk("t1_sops",    64'(n_sop), 64'd2);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);

        // Test 2: same stream with gaps after k=5 (3 cycles) and k=9 (1 cycle).
        do_reset(0, 4);
        for (int k = 0; k < 16; k++) begin
            step(0, 1'b1, 28'(k), 28'(100 + k));
            if (k == 5) for (int g = 0; g < 3; g++) step(0, 1'b0, 28'hBAD, 28'hBAD);
            if (k == 9) step(0, 1'b0, 28'hBEE, 28'hBEE);
        end
        step(0, 1'b0, '0, '0);
        chk("t2_outputs", 64'(n_out), 64'd12);
        chk("t2_sops",    64'(n_sop), 64'd2);

        // Test 3: D=1.
        do_reset(1, 1);
        for (int k = 0; k < 6; k++) step(1, 1'b1, 28'(k), 28'(100 + k));
        step(1, 1'b0, '0, '0);
        chk("t3_outputs", 64'(n_out), 64'd5);
        chk("t3_sops",    64'(n_sop), 64'd3);

        // Test 4: D=4, asynchronous reset after k=6, then a fresh stream.
        do_reset(0, 4);
        for (int k = 0; k < 7; k++) step(0, 1'b1, 28'(k), 28'(100 + k));
        chk("t4_pre_valid", 64'(vo[0]), 64'd1);
        do_reset(0, 4);
        for (int k = 0; k < 8; k++) step(0, 1'b1, 28'(200 + k), 28'(300 + k));
        chk("t4_outputs", 64'(n_out), 64'd4);
        chk("t4_sops",    64'(n_sop), 64'd1);

        // Test 5: D=16, 1024 random pairs at full rate.
        do_reset(2, 16);
        for (int k = 0; k < 1024; k++) step(2, 1'b1, 28'($urandom()), 28'($urandom()));
        step(2, 1'b0, '0, '0);
        chk("t5_outputs", 64'(n_out), 64'd1008);
        chk("t5_sops",    64'(n_sop), 64'd32);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
